// File: rtl/acc_resp_analyzer.sv
// Accumulator-based BIST response analyzer: ones'-complement (end-around carry)
// compaction of response words, then a signature-vs-golden check.
module acc_resp_analyzer #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned NUM_PATTERNS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] seed,
    input  logic [WIDTH-1:0] golden,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] resp,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature,
    output logic [7:0]       count
);

    typedef enum logic [1:0] {StIdle, StRun, StCheck, StDone} state_t;

    localparam logic [7:0] LastCount = NUM_PATTERNS[7:0];

    state_t           state;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] acc_next;
    logic [7:0]       count_inc;

    // End-around carry: the fold cannot overflow since the sum is at most 2*(2^WIDTH-1).
    always_comb begin
        sum       = {1'b0, signature} + {1'b0, resp};
        acc_next  = sum[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, sum[WIDTH]};
        count_inc = count + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            signature <= '0;
            count     <= '0;
            pass      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                StIdle, StDone: begin
                    if (start) begin
                        state     <= StRun;
                        signature <= seed;
                        count     <= '0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end
                end
                StRun: begin
                    if (resp_valid) begin
                        signature <= acc_next;
                        count     <= count_inc;
                        if (count_inc == LastCount) begin
                            state <= StCheck;
                        end
                    end
                end
                StCheck: begin
                    pass  <= (signature == golden);
                    state <= StDone;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acc_resp_analyzer.sv
// Directed bench for acc_resp_analyzer: a 4-pattern instance for the main
// scenarios and a 2-pattern instance for the end-around carry case.
module tb_acc_resp_analyzer;

    logic       clk;
    logic       rst;
    logic       start4;
    logic       start2;
    logic [7:0] seed;
    logic [7:0] golden;
    logic       resp_valid;
    logic [7:0] resp;

    logic       busy4, done4, pass4;
    logic [7:0] sig4, cnt4;
    logic       busy2, done2, pass2;
    logic [7:0] sig2, cnt2;

    int n_vec = 0;
    int n_err = 0;

    // Running signature for seed 0x00 and words 0x01..0x04.
    logic [7:0] exp_part [4] = '{8'h01, 8'h03, 8'h06, 8'h0A};

    acc_resp_analyzer #(.WIDTH(8), .NUM_PATTERNS(4)) u_dut4 (
        .clk        (clk),
        .rst        (rst),
        .start      (start4),
        .seed       (seed),
        .golden     (golden),
        .resp_valid (resp_valid),
        .resp       (resp),
        .busy       (busy4),
        .done       (done4),
        .pass       (pass4),
        .signature  (sig4),
        .count      (cnt4)
    );

    acc_resp_analyzer #(.WIDTH(8), .NUM_PATTERNS(2)) u_dut2 (
        .clk        (clk),
        .rst        (rst),
        .start      (start2),
        .seed       (seed),
        .golden     (golden),
        .resp_valid (resp_valid),
        .resp       (resp),
        .busy       (busy2),
        .done       (done2),
        .pass       (pass2),
        .signature  (sig2),
        .count      (cnt2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One 4-word session on u_dut4 with seed 0x00; optional gaps and a start
    // held high during RUN (seed 0x77) that must be ignored.
    task automatic run_session(input logic [7:0] gold, input int gap, input logic exp_pass,
                               input logic start_in_run);
        seed   = 8'h00;
        golden = gold;
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        check("start_busy", 8'(busy4), 8'd1);
        check("start_done", 8'(done4), 8'd0);
        check("start_pass", 8'(pass4), 8'd0);
        check("start_sig",  sig4, 8'h00);
        check("start_cnt",  cnt4, 8'd0);
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < gap; g++) begin
                resp_valid = 1'b0;
                resp       = 8'hEE;
                step();
                check("gap_cnt", cnt4, 8'(i));
            end
            if (start_in_run) begin
                start4 = 1'b1;
                seed   = 8'h77;
            end
            resp_valid = 1'b1;
            resp       = 8'(i + 1);
            step();
            resp_valid = 1'b0;
            start4     = 1'b0;
            seed       = 8'h00;
            check("acc_sig", sig4, exp_part[i]);
            check("acc_cnt", cnt4, 8'(i + 1));
        end
        check("check_busy", 8'(busy4), 8'd1);
        check("check_done", 8'(done4), 8'd0);
        step();
        check("done_done", 8'(done4), 8'd1);
        check("done_busy", 8'(busy4), 8'd0);
        check("done_pass", 8'(pass4), 8'(exp_pass));
        check("done_sig",  sig4, 8'h0A);
        check("done_cnt",  cnt4, 8'd4);
    endtask

    initial begin
        rst        = 1'b1;
        start4     = 1'b0;
        start2     = 1'b0;
        seed       = 8'h00;
        golden     = 8'h00;
        resp_valid = 1'b0;
        resp       = 8'h00;
        step();
        step();
        check("rst_sig",  sig4, 8'h00);
        check("rst_cnt",  cnt4, 8'd0);
        check("rst_busy", 8'(busy4), 8'd0);
        check("rst_done", 8'(done4), 8'd0);
        check("rst_pass", 8'(pass4), 8'd0);
        rst = 1'b0;

        // Idle ignores resp_valid
        resp_valid = 1'b1;
        resp       = 8'h33;
        step();
        resp_valid = 1'b0;
        check("idle_sig",  sig4, 8'h00);
        check("idle_busy", 8'(busy4), 8'd0);

        // Basic pass, then back-to-back mismatch session started in first DONE cycle
        run_session(8'h0A, 0, 1'b1, 1'b0);
        run_session(8'h0B, 0, 1'b0, 1'b0);

        // Valid gaps, then post-done pulses ignored
        run_session(8'h0A, 3, 1'b1, 1'b0);
        resp_valid = 1'b1;
        resp       = 8'h55;
        step();
        step();
        step();
        resp_valid = 1'b0;
        check("post_sig",  sig4, 8'h0A);
        check("post_cnt",  cnt4, 8'd4);
        check("post_done", 8'(done4), 8'd1);
        check("post_pass", 8'(pass4), 8'd1);

        // Reset mid-RUN after 2 accepts; rst beats a simultaneous start
        seed   = 8'h00;
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            resp_valid = 1'b1;
            resp       = 8'(i + 1);
            step();
        end
        resp_valid = 1'b0;
        check("mid_sig", sig4, 8'h03);
        rst    = 1'b1;
        start4 = 1'b1;
        seed   = 8'h42;
        step();
        rst    = 1'b0;
        start4 = 1'b0;
        check("mrst_sig",  sig4, 8'h00);
        check("mrst_cnt",  cnt4, 8'd0);
        check("mrst_busy", 8'(busy4), 8'd0);
        check("mrst_done", 8'(done4), 8'd0);
        resp_valid = 1'b1;
        resp       = 8'h09;
        step();
        resp_valid = 1'b0;
        check("mrst_idle_sig", sig4, 8'h00);
        run_session(8'h0A, 0, 1'b1, 1'b0);

        // Start during RUN ignored; restart from DONE with seed 0x05
        run_session(8'h0A, 0, 1'b1, 1'b1);
        seed   = 8'h05;
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        check("rs_pass", 8'(pass4), 8'd0);
        check("rs_done", 8'(done4), 8'd0);
        check("rs_busy", 8'(busy4), 8'd1);
        check("rs_sig",  sig4, 8'h05);
        check("rs_cnt",  cnt4, 8'd0);

        // End-around carry on the 2-pattern instance
        seed   = 8'hF0;
        golden = 8'h11;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        check("eac_seed", sig2, 8'hF0);
        resp_valid = 1'b1;
        resp       = 8'h20;
        step();
        check("eac_sig1", sig2, 8'h11);
        check("eac_cnt1", cnt2, 8'd1);
        resp = 8'hFF;
        step();
        resp_valid = 1'b0;
        check("eac_sig2", sig2, 8'h11);
        check("eac_cnt2", cnt2, 8'd2);
        check("eac_busy", 8'(busy2), 8'd1);
        step();
        check("eac_done", 8'(done2), 8'd1);
        check("eac_pass", 8'(pass2), 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
